if_fetch_stage: RTL and testbench



---
 rtl/if_pkg.sv | 6 +
 rtl/if_fetch_stage_if_id_reg.sv | 29 ++
 rtl/if_fetch_stage.sv | 101 ++++++++++
 tb/tb_if_fetch_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage
package if_pkg;
  typedef enum logic {REQ, FULL} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; ports: clk, rst, load/freeze/flush controls (flush > freeze > load), d_pc/d_instr in, pc/instr/valid out
import if_pkg::*;
module if_id_reg #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               freeze,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc <= '0;
      instr <= INSTR_W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (!freeze && load) begin
      pc <= d_pc;
      instr <= d_instr;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, imem request/ack FSM with skid entry and redirect drop flag; ports: clk, rst, hazard, branch_taken/branch_addr, imem_req/addr/ack/rdata, if_id_pc/instr/valid
import if_pkg::*;
module if_fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, req_addr, req_addr_n, skid_pc, skid_pc_n, ld_pc;
  logic [INSTR_W-1:0] skid_instr, skid_instr_n, ld_instr;
  logic drop, drop_n, load;
  assign imem_req = (state == REQ) && !rst;
  assign imem_addr = req_addr;
  always_comb begin
    state_n = state;
    pc_n = pc;
    req_addr_n = req_addr;
    drop_n = drop;
    skid_pc_n = skid_pc;
    skid_instr_n = skid_instr;
    load = 1'b0;
    ld_pc = req_addr + STEP;
    ld_instr = imem_rdata;
    if (branch_taken) begin
      // an unacked request keeps its address on the bus; its data is dropped later
      state_n = REQ;
      pc_n = branch_addr;
      if (state == REQ && !imem_ack) begin
        drop_n = 1'b1;
      end else begin
        req_addr_n = branch_addr;
        drop_n = 1'b0;
      end
    end else if (state == FULL) begin
      if (!hazard) begin
        state_n = REQ;
        req_addr_n = pc;
        load = 1'b1;
        ld_pc = skid_pc;
        ld_instr = skid_instr;
      end
    end else if (imem_ack) begin
      if (drop) begin
        drop_n = 1'b0;
        req_addr_n = pc;
      end else if (hazard) begin
        skid_pc_n = req_addr + STEP;
        skid_instr_n = imem_rdata;
        pc_n = pc + STEP;
        state_n = FULL;
      end else begin
        load = 1'b1;
        pc_n = pc + STEP;
        req_addr_n = pc + STEP;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc <= RESET_PC;
      req_addr <= RESET_PC;
      drop <= 1'b0;
      skid_pc <= '0;
      skid_instr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      req_addr <= req_addr_n;
      drop <= drop_n;
      skid_pc <= skid_pc_n;
      skid_instr <= skid_instr_n;
    end
  end
  if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_if_id (
    .clk(clk),
    .rst(rst),
    .load(load),
    .freeze(hazard),
    .flush(branch_taken),
    .d_pc(ld_pc),
    .d_instr(ld_instr),
    .pc(if_id_pc),
    .instr(if_id_instr),
    .valid(if_id_valid)
  );
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and random checks of if_fetch_stage against a program-order scoreboard
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic rst, hazard, branch_taken, imem_ack, imem_req, if_id_valid;
  logic [31:0] branch_addr, imem_addr, imem_rdata, if_id_pc, if_id_instr;
  logic w_hazard, w_branch, w_ack, w_req, w_valid;
  logic [31:0] w_baddr, w_addr, w_rdata, w_pc, w_instr;
  int n_cmp = 0, n_bad = 0, delivered = 0;
  logic [31:0] q[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata = mem_word(w_addr);
  if_fetch_stage dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );
  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .hazard(w_hazard), .branch_taken(w_branch), .branch_addr(w_baddr),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .if_id_pc(w_pc), .if_id_instr(w_instr), .if_id_valid(w_valid)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  // monitor: captures the inputs applied at each edge, then judges the post-edge outputs
  initial begin
    logic p_req, p_ack, p_br, p_hz, p_rst, o_valid;
    logic [31:0] p_addr, p_baddr, o_pc, o_instr, nxt, a;
    o_valid = 1'b0;
    o_pc = '0;
    o_instr = '0;
    nxt = '0;
    forever begin
      @(negedge clk);
      #3;
      p_req = imem_req; p_ack = imem_ack; p_br = branch_taken; p_hz = hazard; p_rst = rst;
      p_addr = imem_addr; p_baddr = branch_addr;
      @(posedge clk);
      #1;
      if (p_rst) begin
        q.delete();
        nxt = '0;
      end else begin
        if (p_req && !p_ack) begin
          chk1("req_hold", imem_req, 1'b1);
          chk("addr_hold", imem_addr, p_addr);
        end
        if (p_br) begin
          chk1("flush_valid", if_id_valid, 1'b0);
          chk("flush_instr", if_id_instr, 32'h0);
          chk("flush_pc", if_id_pc, 32'h0);
          q.delete();
          nxt = p_baddr;
        end else if (p_hz) begin
          chk("freeze_pc", if_id_pc, o_pc);
          chk("freeze_instr", if_id_instr, o_instr);
          chk1("freeze_valid", if_id_valid, o_valid);
        end else if (if_id_valid && (!o_valid || if_id_pc != o_pc || if_id_instr != o_instr)) begin
          a = q.pop_front();
          chk("sb_pc", if_id_pc, a + 32'd4);
          chk("sb_instr", if_id_instr, mem_word(a));
          delivered++;
        end
      end
      while (q.size() < 4) begin
        q.push_back(nxt);
        nxt += 32'd4;
      end
      o_pc = if_id_pc;
      o_instr = if_id_instr;
      o_valid = if_id_valid;
    end
  end
  initial begin
    rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ack = 1'b0;
    w_hazard = 1'b0; w_branch = 1'b0; w_baddr = '0; w_ack = 1'b1;
    @(negedge clk); @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", if_id_valid, 1'b0);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    rst = 1'b0; imem_ack = 1'b1;
    #1;
    chk("addr0", imem_addr, 32'h0);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("addr4", imem_addr, 32'h4);
    chk("ifid_pc4", if_id_pc, 32'h4);
    chk1("ifid_valid1", if_id_valid, 1'b1);
    chk("wrap_addr1", w_addr, 32'h0);
    chk("wrap_pc", w_pc, 32'h0);
    chk("wrap_instr", w_instr, mem_word(32'hFFFF_FFFC));
    chk1("wrap_req", w_req, 1'b1);
    chk1("wrap_valid", w_valid, 1'b1);
    @(negedge clk);
    chk("addr8", imem_addr, 32'h8);
    chk("ifid_pc8", if_id_pc, 32'h8);
    hazard = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk1("skid_req0", imem_req, 1'b0);
    chk("skid_hold_pc", if_id_pc, 32'h8);
    @(negedge clk); @(negedge clk);
    chk("skid_hold_pc3", if_id_pc, 32'h8);
    hazard = 1'b0;
    @(negedge clk);
    chk("skid_out_pc", if_id_pc, 32'hC);
    chk("skid_out_instr", if_id_instr, mem_word(32'h8));
    chk("skid_next_addr", imem_addr, 32'hC);
    chk1("skid_next_req", imem_req, 1'b1);
    imem_ack = 1'b1;
    for (int i = 0; i < 20 && imem_addr !== 32'h20; i++) @(negedge clk);
    chk("reach_20", imem_addr, 32'h20);
    imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
    @(negedge clk);
    branch_taken = 1'b0;
    chk1("drop_valid", if_id_valid, 1'b0);
    chk("drop_addr1", imem_addr, 32'h20);
    @(negedge clk);
    chk("drop_addr2", imem_addr, 32'h20);
    @(negedge clk);
    chk("drop_addr3", imem_addr, 32'h20);
    imem_ack = 1'b1;
    @(negedge clk);
    chk("drop_next_addr", imem_addr, 32'h100);
    chk1("drop_discard", if_id_valid, 1'b0);
    @(negedge clk);
    chk("tgt_pc", if_id_pc, 32'h104);
    chk("tgt_instr", if_id_instr, mem_word(32'h100));
    hazard = 1'b1;
    @(negedge clk);
    chk1("full_req0", imem_req, 1'b0);
    imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h200;
    @(negedge clk);
    branch_taken = 1'b0; hazard = 1'b0;
    chk1("bh_valid", if_id_valid, 1'b0);
    chk("bh_instr", if_id_instr, 32'h0);
    chk("bh_addr", imem_addr, 32'h200);
    imem_ack = 1'b1;
    @(negedge clk);
    chk("bh_pc", if_id_pc, 32'h204);
    branch_taken = 1'b1; branch_addr = 32'h300;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("ackbr_addr", imem_addr, 32'h300);
    chk1("ackbr_valid", if_id_valid, 1'b0);
    @(negedge clk);
    chk("ackbr_pc", if_id_pc, 32'h304);
    chk("ackbr_instr", if_id_instr, mem_word(32'h300));
    imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk1("midrst_req", imem_req, 1'b0);
    chk1("midrst_valid", if_id_valid, 1'b0);
    chk("midrst_pc", if_id_pc, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      imem_ack = imem_req && ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 599) == 0);
      hazard = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      branch_addr = $urandom();
      @(negedge clk);
    end
    rst = 1'b0; hazard = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    chk1("progress", delivered > 300, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
